// File: rtl/key_pio_pkg.sv
// Shared constants for the key input PIO: register map, edge-type encodings and a
// helper that sizes the per-bit debounce counter.
package key_pio_pkg;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_RSVD = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  localparam int unsigned EDGE_RISE = 0;
  localparam int unsigned EDGE_FALL = 1;
  localparam int unsigned EDGE_ANY  = 2;

  // clog2 of the cycle count, but never zero bits wide (DEBOUNCE_CYCLES = 1).
  function automatic int unsigned cnt_width(input int unsigned cycles);
    return (cycles <= 1) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/key_pio_debounce_if.sv
// Avalon-MM slave bus bundle for the key PIO (zero-latency reads, no waitrequest).
interface key_pio_debounce_if;

  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );

endinterface

// File: rtl/key_debounce_bit.sv
// One key input: 2-FF synchronizer, restartable stability counter, accepted level and
// single-cycle rise/fall pulses coincident with the cycle the accepted level changes.
module key_debounce_bit
  import key_pio_pkg::*;
#(
  parameter int unsigned DebounceCycles = 1000000,
  parameter bit          ResetValue     = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic in_i,
  output logic stable_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned    CntW   = cnt_width(DebounceCycles);
  localparam logic [CntW-1:0] CntMax = CntW'(DebounceCycles - 1);

  logic            sync1_q, sync1_d;
  logic            sync2_q, sync2_d;
  logic            stable_q, stable_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            update;

  always_comb begin
    sync1_d  = in_i;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = '0;
    update   = 1'b0;
    // Any cycle where the synchronized level matches the accepted one restarts the count.
    if (sync2_q != stable_q) begin
      if (cnt_q == CntMax) begin
        update   = 1'b1;
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q  <= ResetValue;
      sync2_q  <= ResetValue;
      stable_q <= ResetValue;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;
  assign rise_o   = update & sync2_q;
  assign fall_o   = update & ~sync2_q;

endmodule

// File: rtl/key_pio_debounce.sv
// Avalon-MM input PIO for keys/switches: debounced data register, interrupt mask,
// write-1-to-clear edge capture and a level irq to the CPU.
module key_pio_debounce
  import key_pio_pkg::*;
#(
  parameter int unsigned      WIDTH           = 4,
  parameter int unsigned      DEBOUNCE_CYCLES = 1000000,
  parameter logic [WIDTH-1:0] RESET_VALUE     = {WIDTH{1'b1}},
  parameter int unsigned      EDGE_TYPE       = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  key_pio_debounce_if.slave        bus,
  input  logic [WIDTH-1:0]         in_port,
  output logic                     irq
);

  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] edge_hit;
  logic [WIDTH-1:0] edge_clr;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] edge_q, edge_d;
  logic [WIDTH-1:0] rd_val;
  logic             wr_en;
  logic             unused_wdata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    key_debounce_bit #(
      .DebounceCycles(DEBOUNCE_CYCLES),
      .ResetValue    (RESET_VALUE[i])
    ) u_bit (
      .clk_i   (clk),
      .rst_i   (reset),
      .in_i    (in_port[i]),
      .stable_o(stable[i]),
      .rise_o  (rise[i]),
      .fall_o  (fall[i])
    );
  end

  // Only the low WIDTH bits of writedata are meaningful.
  assign unused_wdata = ^bus.writedata;
  assign wr_en        = bus.chipselect & ~bus.write_n;

  always_comb begin
    if (EDGE_TYPE == EDGE_RISE) begin
      edge_hit = rise;
    end else if (EDGE_TYPE == EDGE_FALL) begin
      edge_hit = fall;
    end else begin
      edge_hit = rise | fall;
    end
  end

  always_comb begin
    mask_d   = mask_q;
    edge_clr = '0;
    if (wr_en && (bus.address == ADDR_MASK)) begin
      mask_d = bus.writedata[WIDTH-1:0];
    end
    if (wr_en && (bus.address == ADDR_EDGE)) begin
      edge_clr = bus.writedata[WIDTH-1:0];
    end
    // A new edge wins over a simultaneous clear of the same bit.
    edge_d = (edge_q & ~edge_clr) | edge_hit;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mask_q <= '0;
      edge_q <= '0;
    end else begin
      mask_q <= mask_d;
      edge_q <= edge_d;
    end
  end

  always_comb begin
    rd_val = '0;
    unique case (bus.address)
      ADDR_DATA: rd_val = stable;
      ADDR_RSVD: rd_val = '0;
      ADDR_MASK: rd_val = mask_q;
      ADDR_EDGE: rd_val = edge_q;
      default:   rd_val = '0;
    endcase
    bus.readdata = 32'(rd_val);
  end

  assign irq = |(edge_q & mask_q);

endmodule

// File: tb/tb_key_pio_debounce.sv
// Scoreboarded bench: stimulus pushes model predictions, a negedge monitor pops and compares.
module tb_key_pio_debounce;
  import key_pio_pkg::*;

  localparam int          W  = 4;
  localparam int          D  = 4;
  localparam logic [3:0]  RV = 4'hF;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] in_port;
  logic       irq;

  key_pio_debounce_if bus_if ();

  key_pio_debounce #(
    .WIDTH          (W),
    .DEBOUNCE_CYCLES(D),
    .RESET_VALUE    (RV),
    .EDGE_TYPE      (1)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus_if),
    .in_port(in_port),
    .irq    (irq)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  addr;
    logic [31:0] rdata;
    logic        irq;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  bit   check_en = 1'b0;

  // Reference model: a level is accepted once the input seen through the two sync stages
  // has differed from the accepted level for D consecutive cycles.
  logic [3:0] m_stable;
  logic [3:0] m_mask;
  logic [3:0] m_edge;
  logic [3:0] hist[$];
  logic [3:0] cur_in;

  task automatic hist_flush();
    hist.delete();
    repeat (D + 2) hist.push_back(RV);
  endtask

  task automatic model_edge(input logic rst, input logic [3:0] inp, input logic wr,
                            input logic [1:0] addr, input logic [31:0] wd);
    logic [3:0] nxt;
    bit         all_diff;
    if (rst) begin
      m_stable = RV;
      m_mask   = '0;
      m_edge   = '0;
      hist_flush();
    end else begin
      nxt = m_stable;
      for (int b = 0; b < W; b++) begin
        all_diff = 1'b1;
        // Skip the newest sample (still in sync1), inspect the D before it.
        for (int j = 0; j < D; j++) begin
          if (hist[hist.size() - 2 - j][b] == m_stable[b]) all_diff = 1'b0;
        end
        if (all_diff) nxt[b] = ~m_stable[b];
      end
      if (wr && addr == ADDR_EDGE) m_edge = m_edge & ~wd[3:0];
      m_edge = m_edge | (m_stable & ~nxt);
      if (wr && addr == ADDR_MASK) m_mask = wd[3:0];
      m_stable = nxt;
      hist.push_back(inp);
      if (hist.size() > 16) void'(hist.pop_front());
    end
  endtask

  function automatic logic [31:0] model_read(input logic [1:0] addr);
    case (addr)
      ADDR_DATA: return {28'd0, m_stable};
      ADDR_MASK: return {28'd0, m_mask};
      ADDR_EDGE: return {28'd0, m_edge};
      default:   return 32'd0;
    endcase
  endfunction

  task automatic cycle(input logic rst, input logic [3:0] inp, input logic cs, input logic wn,
                       input logic [1:0] addr, input logic [31:0] wd);
    exp_t e;
    reset               = rst;
    in_port             = inp;
    bus_if.chipselect   = cs;
    bus_if.write_n      = wn;
    bus_if.address      = addr;
    bus_if.writedata    = wd;
    if (check_en) begin
      e.addr  = addr;
      e.rdata = model_read(addr);
      e.irq   = |(m_edge & m_mask);
      exp_q.push_back(e);
    end
    @(posedge clk);
    model_edge(rst, inp, cs & ~wn, addr, wd);
    #1;
  endtask

  task automatic rd(input int n, input logic [3:0] inp, input logic [1:0] addr);
    repeat (n) cycle(1'b0, inp, 1'b1, 1'b1, addr, 32'd0);
  endtask

  task automatic wr(input logic [3:0] inp, input logic [1:0] addr, input logic [31:0] wd);
    cycle(1'b0, inp, 1'b1, 1'b0, addr, wd);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      checks++;
      if (bus_if.readdata !== mon_e.rdata || irq !== mon_e.irq) begin
        errors++;
        $display("FAIL read addr=%0d: got readdata=%h irq=%b, want readdata=%h irq=%b (t=%0t)",
                 mon_e.addr, bus_if.readdata, irq, mon_e.rdata, mon_e.irq, $time);
      end
    end
  end

  initial begin
    reset = 1'b1;
    in_port = RV;
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
    bus_if.address    = 2'd0;
    bus_if.writedata  = 32'd0;
    m_stable = RV;
    m_mask   = '0;
    m_edge   = '0;
    hist_flush();
    @(posedge clk);
    #1;
    cycle(1'b1, RV, 1'b0, 1'b1, 2'd0, 32'd0);
    cycle(1'b1, RV, 1'b0, 1'b1, 2'd0, 32'd0);
    check_en = 1'b1;

    // Reset state across the map.
    cycle(1'b1, RV, 1'b0, 1'b1, 2'd0, 32'd0);
    for (int a = 0; a < 4; a++) rd(1, RV, 2'(a));

    // Three-cycle glitch on bit 0 is rejected.
    rd(3, 4'hE, ADDR_DATA);
    rd(6, 4'hF, ADDR_DATA);
    rd(1, 4'hF, ADDR_EDGE);

    // Falling edge, capture, then unmask.
    rd(7, 4'hE, ADDR_DATA);
    rd(1, 4'hE, ADDR_EDGE);
    wr(4'hE, ADDR_MASK, 32'h1);
    rd(2, 4'hE, ADDR_EDGE);

    // W1C, then a rising edge that must not be captured.
    wr(4'hE, ADDR_EDGE, 32'h1);
    rd(1, 4'hE, ADDR_EDGE);
    rd(7, 4'hF, ADDR_DATA);
    rd(1, 4'hF, ADDR_EDGE);

    // Clear of bit 1 lands on the same edge bit 1 falls.
    rd(5, 4'hD, ADDR_EDGE);
    wr(4'hD, ADDR_EDGE, 32'h2);
    rd(2, 4'hD, ADDR_EDGE);

    // Reset while bit 0's count is in progress.
    rd(7, 4'hF, ADDR_DATA);
    rd(4, 4'hE, ADDR_DATA);
    cycle(1'b1, 4'hE, 1'b0, 1'b1, ADDR_DATA, 32'd0);
    rd(7, 4'hE, ADDR_DATA);
    rd(1, 4'hE, ADDR_EDGE);

    // Randomized traffic: slowly toggling keys, random reads/writes, rare resets.
    cur_in = 4'hE;
    for (int n = 0; n < 3000; n++) begin
      logic       r_rst;
      logic       r_cs;
      logic       r_wn;
      for (int b = 0; b < W; b++) begin
        if ($urandom_range(5) == 0) cur_in[b] = ~cur_in[b];
      end
      r_rst = ($urandom_range(299) == 0);
      r_cs  = ($urandom_range(3) != 0);
      r_wn  = ($urandom_range(7) != 0);
      cycle(r_rst, cur_in, r_cs, r_wn, 2'($urandom_range(3)), $urandom);
    end

    for (int t = 0; t < 4 && exp_q.size() != 0; t++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d predictions left, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
